row_tap_gen: RTL and testbench

- Converts a single raster pixel stream into three vertically aligned row taps for the 3x3 window stages (dilate/erode matrix_3x3) that sit directly downstream.
- Holds the two previous image rows in two line delays and emits the current pixel together with the pixels at the same column one and two rows above.
- Rows above the top of the frame are driven as zero.

---
 rtl/row_tap_gen_pkg.sv | 11 +
 rtl/line_delay.sv | 37 +++
 rtl/row_tap_gen.sv | 85 ++++++++
 tb/tb_row_tap_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/row_tap_gen_pkg.sv
// Shared widths and constants for the row tap generator and its line delays.
package row_tap_gen_pkg;

    localparam int COL_W = 11;
    localparam int ROW_W = 11;

    // Wide enough for any supported pixel width; users slice it to WIDTH.
    localparam int MAX_PIXEL_W = 64;
    localparam logic [MAX_PIXEL_W-1:0] ZERO_PIXEL = '0;

endpackage

// File: rtl/line_delay.sv
// One image row of storage: combinational read, synchronous write at the same address.
module line_delay
    import row_tap_gen_pkg::*;
#(
    parameter int DEPTH = 250,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             we,
    input  logic [COL_W-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    idx;

    assign idx   = addr[AW-1:0];
    assign rdata = mem[idx];

    // The column counter never exceeds DEPTH-1, so its upper bits carry no information here.
    generate
        if (AW < COL_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[COL_W-1:AW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/row_tap_gen.sv
// Turns a raster pixel stream into three vertically aligned taps (rows r-2, r-1, r)
// for a downstream 3x3 window; rows above the frame top read as zero.
module row_tap_gen
    import row_tap_gen_pkg::*;
#(
    parameter logic [10:0] PIC_WIDTH  = 11'd250,
    parameter logic [10:0] PIC_HEIGHT = 11'd250,
    parameter int          WIDTH      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             eol_out,
    output logic             eof_out
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [1:0]       rows_filled;
    logic [WIDTH-1:0] rd0;
    logic [WIDTH-1:0] rd1;
    logic             last_col;
    logic             last_row;

    assign last_col = (col == PIC_WIDTH - 11'd1);
    assign last_row = (row == PIC_HEIGHT - 11'd1);

    line_delay #(.DEPTH(int'(PIC_WIDTH)), .WIDTH(WIDTH)) u_line0 (
        .clk   (clk),
        .we    (valid_in),
        .addr  (col),
        .wdata (din),
        .rdata (rd0)
    );

    line_delay #(.DEPTH(int'(PIC_WIDTH)), .WIDTH(WIDTH)) u_line1 (
        .clk   (clk),
        .we    (valid_in),
        .addr  (col),
        .wdata (rd0),
        .rdata (rd1)
    );

    // RAM contents survive across frames; rows_filled masks taps that would reach above row 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            rows_filled <= 2'd0;
            valid_out   <= 1'b0;
            eol_out     <= 1'b0;
            eof_out     <= 1'b0;
            dout1       <= '0;
            dout2       <= '0;
            dout3       <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                dout3   <= din;
                dout2   <= (rows_filled >= 2'd1) ? rd0 : ZERO_PIXEL[WIDTH-1:0];
                dout1   <= (rows_filled >= 2'd2) ? rd1 : ZERO_PIXEL[WIDTH-1:0];
                eol_out <= last_col;
                eof_out <= last_col & last_row;

                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 11'd1;
                    if (last_row) begin
                        rows_filled <= 2'd0;
                    end else if (rows_filled != 2'd2) begin
                        rows_filled <= rows_filled + 2'd1;
                    end
                end else begin
                    col <= col + 11'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_row_tap_gen.sv
// Self-checking bench for row_tap_gen: directed frames plus randomized traffic
// compared against a frame-array reference model.
module tb_row_tap_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] din = '0;
    logic          valid_out;
    logic [DW-1:0] dout1;
    logic [DW-1:0] dout2;
    logic [DW-1:0] dout3;
    logic          eol_out;
    logic          eof_out;

    int total = 0;
    int bad   = 0;

    // Reference model: the pixels of the current frame indexed by (row, col).
    logic [DW-1:0] frame_mem [H][W];
    int            m_row = 0;
    int            m_col = 0;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_d1 = '0;
    logic [DW-1:0] exp_d2 = '0;
    logic [DW-1:0] exp_d3 = '0;
    logic          exp_eol = 1'b0;
    logic          exp_eof = 1'b0;

    row_tap_gen #(
        .PIC_WIDTH  (11'd4),
        .PIC_HEIGHT (11'd3),
        .WIDTH      (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .din       (din),
        .valid_out (valid_out),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3),
        .eol_out   (eol_out),
        .eof_out   (eof_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string phase);
        checkOutput({phase, "/valid_out"}, 32'(valid_out), 32'(exp_valid));
        checkOutput({phase, "/dout1"}, 32'(dout1), 32'(exp_d1));
        checkOutput({phase, "/dout2"}, 32'(dout2), 32'(exp_d2));
        checkOutput({phase, "/dout3"}, 32'(dout3), 32'(exp_d3));
        checkOutput({phase, "/eol_out"}, 32'(eol_out), 32'(exp_eol));
        checkOutput({phase, "/eof_out"}, 32'(eof_out), 32'(exp_eof));
    endtask

    task automatic resetModel();
        m_row     = 0;
        m_col     = 0;
        exp_valid = 1'b0;
        exp_d1    = '0;
        exp_d2    = '0;
        exp_d3    = '0;
        exp_eol   = 1'b0;
        exp_eof   = 1'b0;
    endtask

    // One clock cycle: drive on the falling edge, check 1 ns after the rising edge.
    task automatic applyStimulus(input string phase, input logic v, input logic [DW-1:0] d);
        @(negedge clk);
        valid_in = v;
        din      = d;
        if (rst) begin
            resetModel();
        end else begin
            exp_valid = v;
            if (v) begin
                exp_d3  = d;
                exp_d2  = (m_row >= 1) ? frame_mem[m_row-1][m_col] : '0;
                exp_d1  = (m_row >= 2) ? frame_mem[m_row-2][m_col] : '0;
                exp_eol = (m_col == W - 1);
                exp_eof = (m_col == W - 1) && (m_row == H - 1);
                frame_mem[m_row][m_col] = d;
                if (m_col == W - 1) begin
                    m_col = 0;
                    m_row = (m_row == H - 1) ? 0 : m_row + 1;
                end else begin
                    m_col = m_col + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        checkAll(phase);
    endtask

    task automatic assertReset(input string phase);
        @(negedge clk);
        rst      = 1'b1;
        valid_in = 1'b0;
        #1;
        resetModel();
        checkAll({phase, "/async"});
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic sendFrame(input string phase, input logic [DW-1:0] base, input bit gapped);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                applyStimulus(phase, 1'b1, base + DW'(r * 16 + c));
                if (gapped) begin
                    applyStimulus({phase, "_gap"}, 1'b0, DW'($urandom));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            applyStimulus("reset_hold", 1'(i % 2), DW'($urandom));
        end
        releaseReset();

        sendFrame("frame_cont", 8'h00, 1'b0);
        sendFrame("frame_gap", 8'h00, 1'b1);
        sendFrame("b2b_first", 8'h00, 1'b0);
        sendFrame("b2b_second", 8'h80, 1'b0);

        // Stop part-way into row 1 (next pixel would be row 1, col 2) and reset.
        for (int i = 0; i < W + 2; i++) begin
            applyStimulus("pre_reset", 1'b1, DW'((i / W) * 16 + (i % W)));
        end
        assertReset("mid_reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus("mid_reset_hold", 1'(i % 2), DW'($urandom));
        end
        releaseReset();
        sendFrame("post_reset", 8'h00, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if (i == 217) begin
                assertReset("rand_reset");
                applyStimulus("rand_reset_hold", 1'b1, DW'($urandom));
                releaseReset();
            end
            applyStimulus("random", 1'($urandom_range(0, 99) < 70), DW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
